// File: rtl/morse_receiver.sv
// Morse receiver: classifies light marks into dots/dashes, groups them into letters and decodes 3-bit codes.
// Optional macro MORSE_RX_SYNC_EN inserts a 2-flop input synchronizer in front of the sampling logic.
module morse_receiver #(
  parameter logic [26:0] DOT_MAX = 27'd50000000,
  parameter logic [26:0] GAP_END = 27'd50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       light,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  state_t      state;
  logic [26:0] timer;
  logic [26:0] timer_inc;
  logic [3:0]  bits;
  logic [2:0]  count;
  logic        overflow;
  logic        s;
  logic        is_dash;
  logic        gap_done;
  logic        match;
  logic [2:0]  code;

`ifdef MORSE_RX_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= light;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = light;
`endif

  assign timer_inc = (timer == '1) ? timer : timer + 27'd1;
  // Timer is cleared on each transition, so the run length is timer+1 for a mark
  // and timer+2 for a space (the sample that ended the mark counts as the first low).
  assign is_dash  = (timer >= DOT_MAX);
  assign gap_done = (({1'b0, timer} + 28'd2) >= {1'b0, GAP_END});

  always_comb begin
    match = 1'b1;
    code  = '0;
    case ({count, bits})
      {3'd2, 4'b0010}: code = 3'd0;
      {3'd4, 4'b0001}: code = 3'd1;
      {3'd4, 4'b0101}: code = 3'd2;
      {3'd3, 4'b0001}: code = 3'd3;
      {3'd1, 4'b0000}: code = 3'd4;
      {3'd4, 4'b0100}: code = 3'd5;
      {3'd3, 4'b0111}: code = 3'd6;
      {3'd4, 4'b1111}: code = 3'd7;
      default:         match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      timer    <= '0;
      bits     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      letter   <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (s) begin
            state <= MARK;
            busy  <= 1'b1;
          end
        end
        MARK: begin
          if (s) begin
            timer <= timer_inc;
          end else begin
            if (count == 3'd4) begin
              overflow <= 1'b1;
            end else begin
              bits[count[1:0]] <= is_dash;
              count            <= count + 3'd1;
            end
            timer <= '0;
            state <= SPACE;
          end
        end
        SPACE: begin
          if (s) begin
            timer <= '0;
            state <= MARK;
          end else if (gap_done) begin
            state <= EMIT;
          end else begin
            timer <= timer_inc;
          end
        end
        EMIT: begin
          if (match && !overflow) begin
            letter <= code;
            valid  <= 1'b1;
          end else begin
            error <= 1'b1;
          end
          count    <= '0;
          bits     <= '0;
          overflow <= 1'b0;
          timer    <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: a run-length/pattern-string reference model compared every cycle,
// plus directed letters with hand-computed expectations and a bench-generated loopback stream.
module tb_morse_receiver;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       light  = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  morse_receiver #(.DOT_MAX(27'd4), .GAP_END(27'd8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .light  (light),
    .letter (letter),
    .valid  (valid),
    .error  (error),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  string alpha [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "---", "----"};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks run lengths and the symbol string of the current letter.
  bit    m_in = 0, m_marking = 0, m_emit = 0;
  int    m_high = 0, m_low = 0;
  string m_pat = "";
  bit    m_valid = 0, m_error = 0, m_busy = 0;
  int    m_letter = 0;

  task automatic model_reset();
    m_in = 0; m_marking = 0; m_emit = 0;
    m_high = 0; m_low = 0; m_pat = "";
    m_valid = 0; m_error = 0; m_busy = 0; m_letter = 0;
  endtask

  task automatic model_step(input bit x);
    int code;
    m_valid = 0;
    m_error = 0;
    if (m_emit) begin
      code = -1;
      for (int i = 0; i < 8; i++)
        if (m_pat == alpha[i]) code = i;
      if (code >= 0) begin
        m_valid  = 1;
        m_letter = code;
      end else begin
        m_error = 1;
      end
      m_pat  = "";
      m_in   = 0;
      m_emit = 0;
    end else if (!m_in) begin
      if (x) begin
        m_in = 1; m_marking = 1; m_high = 1;
      end
    end else if (m_marking) begin
      if (x) m_high++;
      else begin
        m_pat     = {m_pat, (m_high > 4) ? "-" : "."};
        m_marking = 0;
        m_low     = 1;
      end
    end else begin
      if (x) begin
        m_marking = 1; m_high = 1;
      end else begin
        m_low++;
        if (m_low == 8) m_emit = 1;
      end
    end
    m_busy = m_in || m_emit;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else model_step(light);
  end

  int n_valid = 0, n_error = 0, last_letter = 0;
  int got_q[$];

  always @(negedge clk) begin
    check("valid",  valid,  m_valid);
    check("error",  error,  m_error);
    check("busy",   busy,   m_busy);
    check("letter", letter, m_letter);
    if (valid && error) check("valid_error_exclusive", 1, 0);
    if (valid) begin
      n_valid++;
      last_letter = letter;
      got_q.push_back(letter);
    end
    if (error) n_error++;
  end

  task automatic mark(input int n);
    light = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic low(input int n);
    light = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input string p);
    for (int i = 0; i < p.len(); i++) begin
      if (i > 0) low(2);
      mark((p.substr(i, i) == "-") ? 6 : 2);
    end
    low(12);
  endtask

  initial begin
    int v0, e0, lat, base;

    repeat (3) @(negedge clk);
    check("reset_letter", letter, 0);
    check("reset_valid",  valid,  0);
    check("reset_busy",   busy,   0);
    #2 resetn = 1'b1;
    low(3);

    // Mark 3, low 3, mark 9, then measure the latency from the fall to valid.
    mark(3); low(3); mark(9);
    v0 = n_valid; e0 = n_error; lat = 0;
    light = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid && lat == 0) lat = i;
    end
    check("t1_latency", lat, 9);
    check("t1_letter",  last_letter, 0);
    check("t1_nvalid",  n_valid - v0, 1);
    check("t1_noerror", n_error - e0, 0);

    // Dot/dash boundary.
    v0 = n_valid; e0 = n_error;
    mark(4); low(12);
    check("dot_max_letter", last_letter, 4);
    check("dot_max_valid",  n_valid - v0, 1);
    mark(5); low(12);
    check("dash_alone_error", n_error - e0, 1);
    check("dash_alone_novalid", n_valid - v0, 1);

    // Five dots overflow the symbol register.
    e0 = n_error; v0 = n_valid;
    for (int i = 0; i < 5; i++) begin
      mark(2);
      low(3);
    end
    low(12);
    check("overflow_error",  n_error - e0, 1);
    check("overflow_novalid", n_valid - v0, 0);
    check("overflow_letter_kept", letter, 4);

    // Space of GAP_END-1 keeps the letter together.
    e0 = n_error; v0 = n_valid;
    mark(2); low(7); mark(2); low(12);
    check("gap7_error",   n_error - e0, 1);
    check("gap7_novalid", n_valid - v0, 0);

    // Reset during the second mark of letter 2.
    e0 = n_error; v0 = n_valid;
    mark(6); low(3);
    light = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_letter", letter, 0);
    check("midreset_valid",  valid,  0);
    check("midreset_error",  error,  0);
    check("midreset_busy",   busy,   0);
    light = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    low(10);
    check("midreset_nopulse", (n_valid - v0) + (n_error - e0), 0);
    send("-.-.");
    check("after_reset_letter", last_letter, 2);
    check("after_reset_valid",  n_valid - v0, 1);

    // Loopback-style stream of letters 0..7.
    e0 = n_error;
    base = got_q.size();
    for (int k = 0; k < 8; k++) send(alpha[k]);
    check("loop_count",   got_q.size() - base, 8);
    check("loop_noerror", n_error - e0, 0);
    for (int k = 0; k < 8; k++)
      if (base + k < got_q.size()) check("loop_letter", got_q[base + k], k);

    low(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
